// File: rtl/seq1100_pkg.sv
// seq1100_pkg: shared state encoding and the single-step overlapping 1100 Mealy detector
package seq1100_pkg;
  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
  typedef struct packed {
    state_t ns;
    logic   match;
  } step_t;
  function automatic step_t step_1100(state_t ps, logic in);
    step_t r;
    r.match = (ps == S3) && !in;
    r.ns = in ? ((ps == S0 || ps == S3) ? S1 : S2) : (ps == S2 ? S3 : S0);
    return r;
  endfunction
endpackage

// File: rtl/seq1100_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search begins at ptr
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any_gnt
);
  logic [CH_W-1:0] idx;
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CH_W'((int'(ptr) + k) % NCH);
      if (!any_gnt && req[idx]) begin
        gnt_idx = idx;
        any_gnt = 1'b1;
      end
    end
    gnt = any_gnt ? NCH'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/seq1100_sched.sv
// seq1100_sched: one 1100 detector time-shared across NCH channels with saved per-channel context
module seq1100_sched
  import seq1100_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CNT_W = 8,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_bit,
  output logic [NCH-1:0]       req_ready,
  input  logic [NCH-1:0]       ch_clr,
  output logic                 det_valid,
  output logic [CH_W-1:0]      det_ch,
  output logic [NCH*CNT_W-1:0] match_cnt
);
  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, det_ch_q, det_ch_d;
  logic            any_gnt, det_valid_q, det_valid_d;
  step_t           step;

  // a channel being cleared is withheld from arbitration that cycle
  rr_arbiter #(.NCH(NCH)) u_arb (
    .req    (req_valid & ~ch_clr),
    .ptr    (rr_ptr_q),
    .gnt    (req_ready),
    .gnt_idx(gnt_idx),
    .any_gnt(any_gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S0;
        cnt_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      det_valid_q <= 1'b0;
      det_ch_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q <= det_ch_d;
    end
  end

  always_comb begin
    step = step_1100(state_q[gnt_idx], req_bit[gnt_idx]);
    rr_ptr_d = any_gnt ? CH_W'((int'(gnt_idx) + 1) % NCH) : rr_ptr_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = ch_clr[i] ? S0 : (any_gnt && gnt_idx == CH_W'(i)) ? step.ns : state_q[i];
      cnt_d[i] = ch_clr[i] ? '0
               : (any_gnt && gnt_idx == CH_W'(i) && step.match && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1)
               : cnt_q[i];
    end
  end

  always_comb begin
    det_valid_d = any_gnt && step.match;
    det_ch_d = det_valid_d ? gnt_idx : det_ch_q;
    det_valid = det_valid_q;
    det_ch = det_ch_q;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign match_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
endmodule
